keccak_squeeze: RTL and testbench
=================================

# keccak_squeeze

Squeeze-side reader for the Keccak core's 5×5×64 state. It accepts a permuted 1600-bit state from the permutation datapath and streams its rate lanes out one 64-bit lane per beat over a valid/ready handshake. It marks the final digest lane. When the digest is longer than the rate, it requests another permutation and resumes streaming from the new state. It sits between the permutation core and the digest output port.

## Interface
- RATE_LANES, 17: lanes per squeeze block (rate/64); legal 1..25; 17 = SHA3-256.
- OUT_LANES, 4: total digest lanes to emit; legal ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- state_in  in  1600  permuted state, flattened `state` type: bit y*320 + x*64 + z = A[y][x][z].
- state_valid  in  1  state_in valid.
- state_ready  out  1  block can capture a state.
- perm_req  out  1  one-cycle pulse: permute the last-delivered state again and re-present it.
- out_data  out  64  current lane.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts beat.
- out_last  out  1  current beat is the final digest lane.

## Operation
- Lane order: lane index i = x + 5*y, taken from bits [64*i +: 64] of the captured state; i runs 0..RATE_LANES-1 within a block.
- Registers:
  - 1600-bit capture register.
  - lane_idx, 0..RATE_LANES-1.
  - emit_cnt, 0..OUT_LANES-1.
  - FSM.
- FSM states:
  - IDLE:
    - state_ready=1.
    - On state_valid: capture state_in, lane_idx=0, emit_cnt=0 → EMIT.
  - EMIT:
    - out_valid=1; out_data = captured lane[lane_idx]; state_ready=0.
    - On a beat (out_valid & out_ready):
      - If emit_cnt==OUT_LANES-1 → IDLE.
      - Else if lane_idx==RATE_LANES-1: emit_cnt++, perm_req=1 for the next cycle only → WAIT_PERM.
      - Else lane_idx++, emit_cnt++.
  - WAIT_PERM:
    - state_ready=1, out_valid=0.
    - On state_valid: capture state_in, lane_idx=0, emit_cnt retained → EMIT.
- out_last = (state==EMIT) & (emit_cnt==OUT_LANES-1).
- state_valid is ignored while in EMIT (state_ready=0); no capture, no error.
- out_data, out_last must be stable while out_valid & !out_ready.
- out_data is 0 when out_valid=0.
- Counter widths: $clog2 of the range, minimum 1 bit. No counter wraps in legal operation.

## Timing
- Reset (rst_n=0, asynchronous), every output immediately:
  - state_ready=1 (FSM=IDLE).
  - out_valid=0, out_last=0, perm_req=0, out_data=0.
  - All counters 0; capture register 0.
- Capture latency: a state handshake in cycle N gives out_valid=1 with lane 0 in cycle N+1.
- Throughput: one lane per cycle with out_ready held high.
- Last beat in cycle M: IDLE in cycle M+1 (state_ready=1, out_valid=0). A state_valid in M+1 is captured; lane 0 appears in M+2.
- Block boundary: beat on lane RATE_LANES-1 in cycle M gives perm_req=1 in M+1 only, with state_ready=1 from M+1 onward. A state_valid coincident with perm_req is legal and is captured.
- Simultaneous completion: when lane_idx==RATE_LANES-1 and emit_cnt==OUT_LANES-1, the block finishes without issuing perm_req.
- Reset mid-operation: abandons the squeeze; outputs take reset values asynchronously. The next state capture restarts at lane 0, emit_cnt 0.

## Test plan
Stimulus convention: lane i of the first state = 64'hA5A5_0000_0000_0000 + i; lane i of the second state = 64'hB6B6_0000_0000_0000 + i.

1. Default parameters, out_ready=1, present the first state:
   - 4 consecutive beats with out_data = ...00, ...01, ...02, ...03.
   - out_last only on the 4th beat.
   - perm_req never asserts.
   - state_ready returns to 1 the cycle after.
2. Backpressure: out_ready=0 for 3 cycles while lane 1 is presented:
   - out_data holds A5A5_..._0001 and out_valid stays 1 throughout.
   - Lane 2 appears the cycle after out_ready rises.
   - Beat count remains 4.
3. RATE_LANES=17, OUT_LANES=21:
   - After 17 beats (lanes 0..16), perm_req pulses exactly 1 cycle.
   - Present the second state.
   - Beats 18..21 = B6B6_..._0000..0003; out_last on beat 21.
4. Assert state_valid with a different state during EMIT:
   - state_ready=0 and the input is ignored.
   - The emitted lanes remain from the first state.
5. Deassert rst_n during EMIT at lane 2:
   - out_valid, out_last, perm_req drop to 0 with no clock edge.
   - After release, the next capture emits from lane 0 with the full OUT_LANES count.
6. RATE_LANES=OUT_LANES=17:
   - 17 beats with out_last on lane 16 (A5A5_..._0010).
   - No perm_req.
   - FSM returns to IDLE.

Source files
------------

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams the rate lanes of a permuted Keccak state out one
// 64-bit lane per beat. When the digest needs more lanes than one block holds,
// it asks the permutation core for another round and resumes on the new state.
module keccak_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    output logic          perm_req,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);
    localparam int LW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam int EW = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(RATE_LANES - 1);
    localparam logic [EW-1:0] EMIT_MAX = EW'(OUT_LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EMIT      = 2'd1,
        S_WAIT_PERM = 2'd2
    } state_t;

    state_t        r_fsm;
    state_t        w_fsm_next;
    logic [1599:0] r_state;
    logic [LW-1:0] r_lane_idx;
    logic [LW-1:0] w_lane_idx_next;
    logic [EW-1:0] r_emit_cnt;
    logic [EW-1:0] w_emit_cnt_next;
    logic          r_perm_req;
    logic          w_perm_req_next;

    logic          w_capture;
    logic          w_beat;
    logic          w_last_lane;
    logic          w_last_emit;
    logic [4:0]    w_lane_sel;
    logic [63:0]   w_lane;
    logic [63:0]   w_lanes [25];

    // Lane i = x + 5*y sits at bits [64*i +: 64] of the flattened state.
    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_lane
            assign w_lanes[gi] = r_state[64*gi +: 64];
        end
    endgenerate

    assign w_lane_sel  = 5'(r_lane_idx);
    assign w_lane      = (w_lane_sel < 5'd25) ? w_lanes[w_lane_sel] : 64'd0;

    assign state_ready = (r_fsm != S_EMIT);
    assign out_valid   = (r_fsm == S_EMIT);
    assign w_capture   = state_ready & state_valid;
    assign w_beat      = out_valid & out_ready;
    assign w_last_lane = (r_lane_idx == LANE_MAX);
    assign w_last_emit = (r_emit_cnt == EMIT_MAX);

    // Data is forced to zero outside EMIT so idle cycles never leak stale lanes.
    assign out_data    = out_valid ? w_lane : 64'd0;
    assign out_last    = out_valid & w_last_emit;
    assign perm_req    = r_perm_req;

    // Next-state and counter update; digest completion wins over the block
    // boundary so a final lane that also ends a block never requests a permute.
    always_comb begin
        w_fsm_next      = r_fsm;
        w_lane_idx_next = r_lane_idx;
        w_emit_cnt_next = r_emit_cnt;
        w_perm_req_next = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (w_capture) begin
                    w_fsm_next      = S_EMIT;
                    w_lane_idx_next = '0;
                    w_emit_cnt_next = '0;
                end
            end
            S_EMIT: begin
                if (w_beat) begin
                    if (w_last_emit) begin
                        w_fsm_next = S_IDLE;
                    end else if (w_last_lane) begin
                        w_fsm_next      = S_WAIT_PERM;
                        w_emit_cnt_next = r_emit_cnt + EW'(1);
                        w_perm_req_next = 1'b1;
                    end else begin
                        w_lane_idx_next = r_lane_idx + LW'(1);
                        w_emit_cnt_next = r_emit_cnt + EW'(1);
                    end
                end
            end
            S_WAIT_PERM: begin
                // The digest count carries across blocks; only the lane restarts.
                if (w_capture) begin
                    w_fsm_next      = S_EMIT;
                    w_lane_idx_next = '0;
                end
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // FSM, counters and the one-cycle permute request pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm      <= S_IDLE;
            r_lane_idx <= '0;
            r_emit_cnt <= '0;
            r_perm_req <= 1'b0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_lane_idx <= w_lane_idx_next;
            r_emit_cnt <= w_emit_cnt_next;
            r_perm_req <= w_perm_req_next;
        end
    end

    // Capture register: loads only when the block is ready, so a state offered
    // during EMIT is dropped silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (w_capture) begin
            r_state <= state_in;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: several parameterisations share one stimulus
// stream; each is checked every cycle against a beat-count reference model.
module tb_keccak_squeeze;
    localparam int NI = 5;
    localparam int RL [NI] = '{17, 17, 17, 3, 1};
    localparam int OL [NI] = '{4, 21, 17, 7, 3};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          out_ready;

    logic [NI-1:0] w_state_ready;
    logic [NI-1:0] w_perm_req;
    logic [NI-1:0] w_out_valid;
    logic [NI-1:0] w_out_last;
    logic [63:0]   w_out_data [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        keccak_squeeze #(
            .RATE_LANES(RL[gi]),
            .OUT_LANES (OL[gi])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .state_in   (state_in),
            .state_valid(state_valid),
            .state_ready(w_state_ready[gi]),
            .perm_req   (w_perm_req[gi]),
            .out_data   (w_out_data[gi]),
            .out_valid  (w_out_valid[gi]),
            .out_ready  (out_ready),
            .out_last   (w_out_last[gi])
        );
    end

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    bit verbose = 1'b0;

    // Reference model: a held block, a running digest beat count k, and
    // whether the squeeze is emitting or waiting on a permutation.
    logic [1599:0] m_blk  [NI];
    int            m_k    [NI];
    bit            m_busy [NI];
    bit            m_wait [NI];
    bit            m_perm [NI];
    int            perm_cnt [NI];

    logic [64:0] log0 [$];
    logic [64:0] log1 [$];
    logic [64:0] log2 [$];

    function automatic logic [1599:0] mk_state(input logic [15:0] tag);
        logic [1599:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[64*i +: 64] = {tag, 48'(i)};
        return s;
    endfunction

    task automatic cmp(input string nm, input int n, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, n, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int n);
        m_busy[n] = 1'b0;
        m_wait[n] = 1'b0;
        m_perm[n] = 1'b0;
        m_k[n]    = 0;
    endtask

    task automatic model_step(input int n);
        bit np;
        np = 1'b0;
        if (m_busy[n]) begin
            if (out_ready) begin
                if (m_k[n] == OL[n] - 1) begin
                    m_busy[n] = 1'b0;
                    m_k[n]    = 0;
                end else begin
                    if ((m_k[n] % RL[n]) == RL[n] - 1) begin
                        m_busy[n] = 1'b0;
                        m_wait[n] = 1'b1;
                        np        = 1'b1;
                    end
                    m_k[n]++;
                end
            end
        end else if (state_valid) begin
            m_blk[n]  = state_in;
            m_busy[n] = 1'b1;
            if (!m_wait[n]) m_k[n] = 0;
            m_wait[n] = 1'b0;
        end
        m_perm[n] = np;
    endtask

    task automatic log_beat(input int n, input logic [64:0] v);
        case (n)
            0: log0.push_back(v);
            1: log1.push_back(v);
            2: log2.push_back(v);
            default: ;
        endcase
        if (verbose) $display("beat inst%0d data=%h last=%b", n, v[63:0], v[64]);
    endtask

    function automatic int log_size(input int n);
        case (n)
            0: return log0.size();
            1: return log1.size();
            default: return log2.size();
        endcase
    endfunction

    function automatic logic [64:0] log_get(input int n, input int idx);
        if (idx >= log_size(n)) return 65'd0;
        case (n)
            0: return log0[idx];
            1: return log1[idx];
            default: return log2[idx];
        endcase
    endfunction

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        log2.delete();
        for (int n = 0; n < NI; n++) perm_cnt[n] = 0;
    endtask

    // Per-cycle compare of every instance against the model, then advance the model.
    task automatic cycle_check();
        for (int n = 0; n < NI; n++) begin
            logic [63:0] ed;
            logic ev, el, ep;
            if (!rst_n) model_reset(n);
            ev = m_busy[n];
            el = m_busy[n] && (m_k[n] == OL[n] - 1);
            ed = m_busy[n] ? m_blk[n][64*(m_k[n] % RL[n]) +: 64] : 64'd0;
            ep = m_perm[n];
            cmp("out_valid",   n, 64'(w_out_valid[n]),   64'(ev));
            cmp("state_ready", n, 64'(w_state_ready[n]), 64'(!ev));
            cmp("out_last",    n, 64'(w_out_last[n]),    64'(el));
            cmp("perm_req",    n, 64'(w_perm_req[n]),    64'(ep));
            cmp("out_data",    n, w_out_data[n],         ed);
            if (w_perm_req[n]) perm_cnt[n]++;
            if (w_out_valid[n] && out_ready) log_beat(n, {w_out_last[n], w_out_data[n]});
            if (rst_n) model_step(n);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    // Checks reset values without waiting for any clock edge.
    task automatic reset_now_check();
        for (int n = 0; n < NI; n++) begin
            model_reset(n);
            cmp("rst_out_valid",   n, 64'(w_out_valid[n]),   64'd0);
            cmp("rst_out_last",    n, 64'(w_out_last[n]),    64'd0);
            cmp("rst_perm_req",    n, 64'(w_perm_req[n]),    64'd0);
            cmp("rst_out_data",    n, w_out_data[n],         64'd0);
            cmp("rst_state_ready", n, 64'(w_state_ready[n]), 64'd1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        reset_now_check();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_lanes(input string nm, input int n, input int cnt,
                               input int first_blk, input int rate);
        cmp({nm, "_count"}, n, 64'(log_size(n)), 64'(cnt));
        for (int j = 0; j < cnt; j++) begin
            logic [64:0] v;
            logic [63:0] ed;
            v  = log_get(n, j);
            ed = (j < first_blk) ? {16'hA5A5, 48'(j)} : {16'hB6B6, 48'(j - rate)};
            cmp({nm, "_data"}, n, v[63:0], ed);
            cmp({nm, "_last"}, n, 64'(v[64]), 64'(j == cnt - 1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n       = 1'b1;
        state_in    = '0;
        state_valid = 1'b0;
        out_ready   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        reset_now_check();
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // First state everywhere, a different state offered during EMIT,
        // then the second state coincident with instance 1's permute request.
        clear_logs();
        verbose     = 1'b1;
        state_valid = 1'b1;
        state_in    = mk_state(16'hA5A5);
        step();
        state_in = mk_state(16'hC7C7);
        step();
        step();
        step();
        state_valid = 1'b0;
        state_in    = '0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (m_perm[1]) found = 1'b1;
            else step();
        end
        if (!found) begin
            n_vec++;
            n_mis++;
            $display("FAIL perm_wait inst1: got no perm_req within 40 cycles, required one");
        end
        check_lanes("short_digest", 0, 4, 4, 17);
        check_lanes("full_block", 2, 17, 17, 17);
        cmp("no_perm_short", 0, 64'(perm_cnt[0]), 64'd0);
        cmp("no_perm_full",  2, 64'(perm_cnt[2]), 64'd0);
        state_valid = 1'b1;
        state_in    = mk_state(16'hB6B6);
        step();
        state_valid = 1'b0;
        state_in    = '0;
        for (int c = 0; c < 10; c++) step();
        check_lanes("two_block", 1, 21, 17, 17);
        cmp("perm_pulses", 1, 64'(perm_cnt[1]), 64'd1);

        // Backpressure while lane 1 is presented.
        do_reset();
        clear_logs();
        state_valid = 1'b1;
        state_in    = mk_state(16'hA5A5);
        step();
        state_valid = 1'b0;
        out_ready   = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        step();
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check_lanes("backpressure", 0, 4, 4, 17);

        // Reset while lane 2 is presented, then a fresh squeeze.
        do_reset();
        state_valid = 1'b1;
        state_in    = mk_state(16'hA5A5);
        step();
        state_valid = 1'b0;
        step();
        step();
        do_reset();
        clear_logs();
        state_valid = 1'b1;
        state_in    = mk_state(16'hB6B6);
        step();
        state_valid = 1'b0;
        for (int c = 0; c < 8; c++) step();
        check_lanes("after_reset", 0, 4, 0, 0);

        // Randomised traffic with occasional resets.
        verbose = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                state_valid = ($urandom_range(0, 9) < 3);
                for (int i = 0; i < 50; i++) state_in[32*i +: 32] = $urandom;
                out_ready = ($urandom_range(0, 9) < 7);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
